// File: rtl/oled_pkg.sv
// Shared definitions for the OLED SPI arbiter: FSM state encoding and
// requester index constants.
package oled_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ARB,
      CS_SETUP,
      LOAD,
      SHIFT,
      CS_HOLD,
      GAP
   } state_t;

   localparam int REQ_INIT = 0;
   localparam int REQ_HOST = 1;

endpackage

// File: rtl/spi_byte_tx.sv
// SPI mode-0 byte shifter: MSB first, SCLK low then high for HALF_DIV clk
// cycles per bit, so one byte occupies 16*HALF_DIV cycles after start.
module spi_byte_tx #(
   parameter int HALF_DIV = 2
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       start,
   input  logic [7:0] tx_byte,
   output logic       sclk,
   output logic       sdin,
   output logic       done
);

   logic       r_active;
   logic [7:0] r_div;
   logic [2:0] r_bit;
   logic [7:0] r_sr;
   logic       r_sclk;
   logic       r_sdin;
   logic       w_phase_end;

   assign w_phase_end = r_active && (r_div == 8'(HALF_DIV - 1));
   // High during the final cycle of the last high phase of bit 0.
   assign done = w_phase_end && r_sclk && (r_bit == 3'd7);
   assign sclk = r_sclk;
   assign sdin = r_sdin;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_active <= 1'b0;
         r_div    <= '0;
         r_bit    <= '0;
         r_sr     <= '0;
         r_sclk   <= 1'b0;
         r_sdin   <= 1'b0;
      end else if (start) begin
         r_active <= 1'b1;
         r_div    <= '0;
         r_bit    <= '0;
         r_sr     <= {tx_byte[6:0], 1'b0};
         r_sclk   <= 1'b0;
         r_sdin   <= tx_byte[7];
      end else if (r_active) begin
         if (w_phase_end) begin
            r_div <= '0;
            if (!r_sclk) begin
               r_sclk <= 1'b1;
            end else begin
               // Falling edge: next bit is presented while SCLK is low.
               r_sclk <= 1'b0;
               if (r_bit == 3'd7) begin
                  r_active <= 1'b0;
                  r_sdin   <= 1'b0;
               end else begin
                  r_bit  <= r_bit + 3'd1;
                  r_sdin <= r_sr[7];
                  r_sr   <= {r_sr[6:0], 1'b0};
               end
            end
         end else begin
            r_div <= r_div + 8'd1;
         end
      end
   end

endmodule

// File: rtl/oled_spi_arbiter.sv
// Two-requester, packet-granular arbiter in front of an OLED SPI link.
// Requester 0 (power-on init) wins ties; the owner keeps CS until its last byte.
module oled_spi_arbiter
   import oled_pkg::*;
#(
   parameter int HALF_DIV = 2,
   parameter int CS_GAP   = 2
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [1:0]  rq_valid,
   input  logic [15:0] rq_data,
   input  logic [1:0]  rq_dc,
   input  logic [1:0]  rq_last,
   output logic [1:0]  rq_ready,
   output logic [1:0]  grant,
   output logic        busy,
   output logic        oled_sclk,
   output logic        oled_sdin,
   output logic        oled_cs,
   output logic        oled_d_cn
);

   state_t     r_state;
   logic [7:0] r_cnt;
   logic [1:0] r_grant;
   logic [1:0] r_ready;
   logic       r_busy;
   logic       r_cs;
   logic       r_dc;
   logic       r_last;

   logic       w_gvalid;
   logic [7:0] w_gdata;
   logic       w_gdc;
   logic       w_glast;
   logic       w_start;
   logic       w_done;

   assign w_gvalid = |(rq_valid & r_grant);
   assign w_gdata  = r_grant[REQ_HOST] ? rq_data[15:8]     : rq_data[7:0];
   assign w_gdc    = r_grant[REQ_HOST] ? rq_dc[REQ_HOST]   : rq_dc[REQ_INIT];
   assign w_glast  = r_grant[REQ_HOST] ? rq_last[REQ_HOST] : rq_last[REQ_INIT];
   // The byte is taken in the cycle rq_ready is visible to the requester.
   assign w_start  = (r_state == LOAD) && (r_ready != 2'b00) && w_gvalid;

   spi_byte_tx #(
      .HALF_DIV(HALF_DIV)
   ) u_tx (
      .clk     (clk),
      .resetn  (resetn),
      .start   (w_start),
      .tx_byte (w_gdata),
      .sclk    (oled_sclk),
      .sdin    (oled_sdin),
      .done    (w_done)
   );

   assign rq_ready  = r_ready;
   assign grant     = r_grant;
   assign busy      = r_busy;
   assign oled_cs   = r_cs;
   assign oled_d_cn = r_dc;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_grant <= '0;
         r_ready <= '0;
         r_busy  <= 1'b0;
         r_cs    <= 1'b1;
         r_dc    <= 1'b0;
         r_last  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (|rq_valid) begin
                  r_state <= ARB;
                  r_busy  <= 1'b1;
                  r_grant <= rq_valid[REQ_INIT] ? 2'(1 << REQ_INIT) : 2'(1 << REQ_HOST);
               end
            end
            ARB: begin
               r_state <= CS_SETUP;
               r_cs    <= 1'b0;
               r_cnt   <= '0;
            end
            CS_SETUP: begin
               if (r_cnt == 8'(HALF_DIV - 1)) begin
                  r_state <= LOAD;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            LOAD: begin
               // Ready is registered, so it never coincides with a fresh valid.
               if (r_ready != 2'b00) begin
                  r_ready <= '0;
                  if (w_gvalid) begin
                     r_dc    <= w_gdc;
                     r_last  <= w_glast;
                     r_state <= SHIFT;
                  end
               end else if (w_gvalid) begin
                  r_ready <= r_grant;
               end
            end
            SHIFT: begin
               if (w_done) begin
                  r_state <= r_last ? CS_HOLD : LOAD;
                  r_cnt   <= '0;
               end
            end
            CS_HOLD: begin
               if (r_cnt == 8'(HALF_DIV - 1)) begin
                  r_state <= GAP;
                  r_cnt   <= '0;
                  r_cs    <= 1'b1;
                  r_grant <= '0;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            GAP: begin
               if (r_cnt == 8'(CS_GAP - 1)) begin
                  r_state <= IDLE;
                  r_cnt   <= '0;
                  r_busy  <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_oled_spi_arbiter.sv
// Bench for oled_spi_arbiter: queued requester drivers, an SPI bus decoder and
// a per-requester byte-stream reference compared after each scenario.
module tb_oled_spi_arbiter;

   localparam int HD   = 2;
   localparam int GAPC = 2;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic [1:0]  rq_valid;
   logic [15:0] rq_data;
   logic [1:0]  rq_dc;
   logic [1:0]  rq_last;
   logic [1:0]  rq_ready;
   logic [1:0]  grant;
   logic        busy;
   logic        oled_sclk;
   logic        oled_sdin;
   logic        oled_cs;
   logic        oled_d_cn;

   oled_spi_arbiter #(.HALF_DIV(HD), .CS_GAP(GAPC)) dut (
      .clk(clk), .resetn(resetn), .rq_valid(rq_valid), .rq_data(rq_data),
      .rq_dc(rq_dc), .rq_last(rq_last), .rq_ready(rq_ready), .grant(grant),
      .busy(busy), .oled_sclk(oled_sclk), .oled_sdin(oled_sdin),
      .oled_cs(oled_cs), .oled_d_cn(oled_d_cn)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         gap;
      logic [7:0] data;
      logic       dc;
      logic       last;
   } txb_t;

   txb_t        tx_q0[$];
   txb_t        tx_q1[$];
   logic [9:0]  exp0[$];
   logic [9:0]  exp1[$];
   logic [10:0] rx_q[$];

   int n_pass = 0;
   int n_total = 0;
   int cyc = 0;
   int viol, rdy_cnt0, rdy_cnt1, rise_cnt, cs_fall_cnt, nbits;
   int t_cs_fall, t_cs_rise, t_first_rise, min_cs_high, cs_hi_run;
   bit had_frame, first_rise;

   function automatic void push(input bit src, input logic [7:0] d, input logic dc,
                                input logic last, input int gap);
      txb_t b;
      b.gap = gap; b.data = d; b.dc = dc; b.last = last;
      if (src) begin tx_q1.push_back(b); exp1.push_back({last, dc, d}); end
      else     begin tx_q0.push_back(b); exp0.push_back({last, dc, d}); end
   endfunction

   // Each requester's bytes must appear on the bus in its own order with its own framing.
   function automatic int stream_errors();
      int e = 0;
      int i0 = 0;
      int i1 = 0;
      foreach (rx_q[k]) begin
         if (rx_q[k][10] == 1'b0) begin
            if (i0 >= exp0.size() || rx_q[k][9:0] !== exp0[i0]) e++;
            i0++;
         end else begin
            if (i1 >= exp1.size() || rx_q[k][9:0] !== exp1[i1]) e++;
            i1++;
         end
      end
      if (i0 != exp0.size() || i1 != exp1.size()) e++;
      return e;
   endfunction

   task automatic clear_logs();
      rx_q.delete(); exp0.delete(); exp1.delete();
      viol = 0; rdy_cnt0 = 0; rdy_cnt1 = 0; rise_cnt = 0; cs_fall_cnt = 0;
      t_cs_fall = 0; t_cs_rise = 0; t_first_rise = 0;
      min_cs_high = 1000000; had_frame = 0;
   endtask

   task automatic wait_quiet(input int budget, output bit to);
      to = 1'b1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (tx_q0.size() == 0 && tx_q1.size() == 0 && !busy) begin
            to = 1'b0;
            break;
         end
      end
      repeat (2) @(negedge clk);
   endtask

   // Requester drivers: present queue head once its leading gap has elapsed.
   initial begin : drv
      logic [1:0] hs;
      rq_valid = '0; rq_data = '0; rq_dc = '0; rq_last = '0;
      forever begin
         @(negedge clk);
         hs = rq_valid & rq_ready;
         @(posedge clk);
         #1;
         if (!resetn) begin
            tx_q0.delete(); tx_q1.delete();
            rq_valid = '0;
         end else begin
            if (hs[0]) void'(tx_q0.pop_front());
            if (hs[1]) void'(tx_q1.pop_front());
            if (tx_q0.size() > 0 && tx_q0[0].gap > 0) tx_q0[0].gap = tx_q0[0].gap - 1;
            if (tx_q1.size() > 0 && tx_q1[0].gap > 0) tx_q1[0].gap = tx_q1[0].gap - 1;
            rq_valid[0] = (tx_q0.size() > 0) && (tx_q0[0].gap == 0);
            rq_valid[1] = (tx_q1.size() > 0) && (tx_q1[0].gap == 0);
         end
         rq_data[7:0]  = rq_valid[0] ? tx_q0[0].data : 8'($urandom);
         rq_dc[0]      = rq_valid[0] ? tx_q0[0].dc   : 1'($urandom);
         rq_last[0]    = rq_valid[0] ? tx_q0[0].last : 1'($urandom);
         rq_data[15:8] = rq_valid[1] ? tx_q1[0].data : 8'($urandom);
         rq_dc[1]      = rq_valid[1] ? tx_q1[0].dc   : 1'($urandom);
         rq_last[1]    = rq_valid[1] ? tx_q1[0].last : 1'($urandom);
      end
   end

   // Bus decoder and protocol watcher, sampling on the falling clk edge.
   initial begin : mon
      logic p_sclk, p_sdin, p_cs, p_dc, byte_dc;
      logic [1:0] p_grant;
      logic [7:0] sh;
      logic [10:0] tmp;
      p_sclk = 0; p_sdin = 0; p_cs = 1; p_dc = 0; p_grant = 0; sh = 0; byte_dc = 0;
      nbits = 0; cs_hi_run = 0; first_rise = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (!resetn) begin
            nbits = 0; p_sclk = 0; p_sdin = 0; p_cs = 1; p_dc = 0; p_grant = 0;
            cs_hi_run = 0; had_frame = 0;
         end else begin
            if (rq_ready[0]) rdy_cnt0++;
            if (rq_ready[1]) rdy_cnt1++;
            if ((rq_ready & ~grant) != 2'b00) viol++;
            if (oled_sdin !== p_sdin && oled_sclk) viol++;
            if (oled_cs && (oled_sclk || oled_sdin)) viol++;
            if ((grant & (grant - 2'd1)) != 2'b00) viol++;
            if ((grant != 2'b00 || !oled_cs) && !busy) viol++;
            if (!oled_cs && !p_cs && grant != p_grant) viol++;
            if (oled_sclk && oled_d_cn !== p_dc) viol++;
            if (p_cs && !oled_cs) begin
               cs_fall_cnt++;
               t_cs_fall = cyc;
               first_rise = 1;
               if (had_frame && cs_hi_run < min_cs_high) min_cs_high = cs_hi_run;
            end
            cs_hi_run = oled_cs ? cs_hi_run + 1 : 0;
            if (!p_sclk && oled_sclk) begin
               rise_cnt++;
               if (first_rise) begin t_first_rise = cyc; first_rise = 0; end
               if (nbits == 0) byte_dc = oled_d_cn;
               else if (oled_d_cn !== byte_dc) viol++;
               sh = {sh[6:0], oled_sdin};
               nbits++;
               if (nbits == 8) begin
                  rx_q.push_back({grant[1], 1'b0, byte_dc, sh});
                  nbits = 0;
               end
            end
            if (!p_cs && oled_cs) begin
               t_cs_rise = cyc;
               had_frame = 1;
               if (nbits != 0 || rx_q.size() == 0) viol++;
               else begin
                  tmp = rx_q.pop_back();
                  tmp[9] = 1'b1;
                  rx_q.push_back(tmp);
               end
            end
            p_sclk = oled_sclk; p_sdin = oled_sdin; p_cs = oled_cs;
            p_dc = oled_d_cn; p_grant = grant;
         end
      end
   end

   task automatic test_reset();
      resetn = 1'b0;
      repeat (3) @(negedge clk);
      n_total++;
      if ({oled_cs, oled_sclk, oled_sdin, oled_d_cn} !== 4'b1000)
         $display("FAIL reset_pins: got cs,sclk,sdin,dcn=%b expected 1000",
                  {oled_cs, oled_sclk, oled_sdin, oled_d_cn});
      else n_pass++;
      n_total++;
      if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
      n_total++;
      if (grant !== 2'b00) $display("FAIL reset_grant: got %b expected 00", grant); else n_pass++;
      n_total++;
      if (rq_ready !== 2'b00) $display("FAIL reset_ready: got %b expected 00", rq_ready); else n_pass++;
      #2 resetn = 1'b1;
      repeat (4) @(negedge clk);
      n_total++;
      if ({busy, oled_cs} !== 2'b01) $display("FAIL idle_after_reset: got busy,cs=%b expected 01", {busy, oled_cs});
      else n_pass++;
   endtask

   task automatic test_single_cmd();
      bit to;
      clear_logs();
      push(1'b0, 8'hAF, 1'b0, 1'b1, 0);
      wait_quiet(2000, to);
      n_total++;
      if (to) $display("FAIL single_timeout: got timeout=1 expected 0"); else n_pass++;
      n_total++;
      if (stream_errors() !== 0) $display("FAIL single_stream: got %0d errors (rx=%0d bytes) expected 0", stream_errors(), rx_q.size());
      else n_pass++;
      n_total++;
      if ({rdy_cnt0, rdy_cnt1} !== {32'd1, 32'd0}) $display("FAIL single_ready: got %0d/%0d pulses expected 1/0", rdy_cnt0, rdy_cnt1);
      else n_pass++;
      n_total++;
      if ((t_first_rise - t_cs_fall) < HD) $display("FAIL single_cs_setup: got %0d cycles expected >= %0d", t_first_rise - t_cs_fall, HD);
      else n_pass++;
      // Low phase before first rise + 8 bits + CS hold, measured from the first rise.
      n_total++;
      if ((t_cs_rise - t_first_rise) !== (16 * HD + HD - HD)) $display("FAIL single_cs_release: got %0d cycles expected %0d", t_cs_rise - t_first_rise, 16 * HD);
      else n_pass++;
      n_total++;
      if (rise_cnt !== 8) $display("FAIL single_edges: got %0d sclk rises expected 8", rise_cnt); else n_pass++;
      n_total++;
      if (viol !== 0) $display("FAIL single_protocol: got %0d violations expected 0", viol); else n_pass++;
   endtask

   task automatic test_data_byte();
      bit to;
      clear_logs();
      push(1'b0, 8'hF8, 1'b1, 1'b1, 0);
      wait_quiet(2000, to);
      n_total++;
      if (to || rx_q.size() != 1) $display("FAIL data_count: got timeout=%0d bytes=%0d expected 0/1", to, rx_q.size());
      else begin
         n_pass++;
         n_total++;
         if (rx_q[0][8] !== 1'b1) $display("FAIL data_dcn: got %b expected 1", rx_q[0][8]); else n_pass++;
      end
      n_total++;
      if (stream_errors() !== 0) $display("FAIL data_stream: got %0d errors expected 0", stream_errors()); else n_pass++;
      n_total++;
      if (viol !== 0) $display("FAIL data_protocol: got %0d violations expected 0", viol); else n_pass++;
   endtask

   task automatic test_priority();
      bit to;
      clear_logs();
      push(1'b0, 8'h3C, 1'b0, 1'b0, 0);
      push(1'b0, 8'h5A, 1'b1, 1'b1, 0);
      push(1'b1, 8'hC3, 1'b1, 1'b1, 0);
      wait_quiet(3000, to);
      n_total++;
      if (to || rx_q.size() != 3) $display("FAIL prio_count: got timeout=%0d bytes=%0d expected 0/3", to, rx_q.size());
      else begin
         n_pass++;
         n_total++;
         if ({rx_q[0][10], rx_q[1][10], rx_q[2][10]} !== 3'b001)
            $display("FAIL prio_order: got sources %b expected 001", {rx_q[0][10], rx_q[1][10], rx_q[2][10]});
         else n_pass++;
      end
      n_total++;
      if (stream_errors() !== 0) $display("FAIL prio_stream: got %0d errors expected 0", stream_errors()); else n_pass++;
      n_total++;
      if (cs_fall_cnt !== 2 || min_cs_high < GAPC) $display("FAIL prio_gap: got frames=%0d min_cs_high=%0d expected 2 and >= %0d", cs_fall_cnt, min_cs_high, GAPC);
      else n_pass++;
      n_total++;
      if (viol !== 0) $display("FAIL prio_protocol: got %0d violations expected 0", viol); else n_pass++;
   endtask

   task automatic test_multi();
      bit to;
      clear_logs();
      push(1'b1, 8'h15, 1'b0, 1'b0, 0);
      push(1'b1, 8'h00, 1'b0, 1'b0, 0);
      push(1'b1, 8'h5F, 1'b0, 1'b1, 0);
      wait_quiet(3000, to);
      n_total++;
      if (to) $display("FAIL multi_timeout: got timeout=1 expected 0"); else n_pass++;
      n_total++;
      if (stream_errors() !== 0) $display("FAIL multi_stream: got %0d errors expected 0", stream_errors()); else n_pass++;
      n_total++;
      if ({cs_fall_cnt, rise_cnt} !== {32'd1, 32'd24}) $display("FAIL multi_frame: got frames=%0d rises=%0d expected 1/24", cs_fall_cnt, rise_cnt);
      else n_pass++;
      n_total++;
      if ({rdy_cnt0, rdy_cnt1} !== {32'd0, 32'd3}) $display("FAIL multi_ready: got %0d/%0d pulses expected 0/3", rdy_cnt0, rdy_cnt1);
      else n_pass++;
   endtask

   task automatic test_stall();
      bit to;
      int bad;
      clear_logs();
      push(1'b1, 8'hA5, 1'b1, 1'b0, 0);
      push(1'b1, 8'h81, 1'b0, 1'b1, 50);
      to = 1'b1;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (rdy_cnt1 == 1) begin to = 1'b0; break; end
      end
      n_total++;
      if (to) $display("FAIL stall_first_ready: got timeout=1 expected 0"); else n_pass++;
      repeat (36) @(negedge clk);
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         if (oled_cs !== 1'b0 || oled_sclk !== 1'b0 || rq_ready !== 2'b00 || busy !== 1'b1) bad++;
         @(negedge clk);
      end
      n_total++;
      if (bad !== 0) $display("FAIL stall_hold: got %0d bad cycles expected 0", bad); else n_pass++;
      wait_quiet(3000, to);
      n_total++;
      if (to || stream_errors() !== 0) $display("FAIL stall_stream: got timeout=%0d errors=%0d expected 0/0", to, stream_errors());
      else n_pass++;
      n_total++;
      if ({cs_fall_cnt, rdy_cnt1} !== {32'd1, 32'd2}) $display("FAIL stall_frame: got frames=%0d ready=%0d expected 1/2", cs_fall_cnt, rdy_cnt1);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      bit to;
      int rises;
      clear_logs();
      push(1'b0, 8'hFF, 1'b1, 1'b1, 0);
      to = 1'b1;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (nbits == 4) begin to = 1'b0; break; end
      end
      n_total++;
      if (to) $display("FAIL rstmid_reach: got timeout=1 expected 0"); else n_pass++;
      #2 resetn = 1'b0;
      #1;
      n_total++;
      if ({oled_cs, oled_sclk, oled_sdin, oled_d_cn, busy, grant, rq_ready} !== 9'b1_0000_0000)
         $display("FAIL rstmid_async: got %b expected 100000000",
                  {oled_cs, oled_sclk, oled_sdin, oled_d_cn, busy, grant, rq_ready});
      else n_pass++;
      repeat (3) @(negedge clk);
      #2 resetn = 1'b1;
      rises = rise_cnt;
      repeat (40) @(negedge clk);
      n_total++;
      if (rise_cnt !== rises || rx_q.size() != 0) $display("FAIL rstmid_residual: got %0d rises %0d bytes expected 0/0", rise_cnt - rises, rx_q.size());
      else n_pass++;
      n_total++;
      if ({busy, oled_cs, grant} !== 4'b0100) $display("FAIL rstmid_idle: got busy,cs,grant=%b expected 0100", {busy, oled_cs, grant});
      else n_pass++;
   endtask

   task automatic test_random();
      bit to;
      int npk;
      int len;
      npk = 0;
      clear_logs();
      for (int p = 0; p < 6; p++) begin
         for (int s = 0; s < 2; s++) begin
            len = int'($urandom_range(1, 4));
            for (int b = 0; b < len; b++)
               push(s[0], 8'($urandom), 1'($urandom), (b == len - 1),
                    (b == 0 && p == 0) ? 0 : int'($urandom_range(0, 6)));
            npk++;
         end
      end
      wait_quiet(20000, to);
      n_total++;
      if (to) $display("FAIL rand_timeout: got timeout=1 expected 0"); else n_pass++;
      n_total++;
      if (stream_errors() !== 0) $display("FAIL rand_stream: got %0d errors expected 0", stream_errors()); else n_pass++;
      n_total++;
      if (rdy_cnt0 !== exp0.size() || rdy_cnt1 !== exp1.size())
         $display("FAIL rand_ready: got %0d/%0d pulses expected %0d/%0d", rdy_cnt0, rdy_cnt1, exp0.size(), exp1.size());
      else n_pass++;
      n_total++;
      if (cs_fall_cnt !== npk || min_cs_high < GAPC)
         $display("FAIL rand_frames: got frames=%0d min_cs_high=%0d expected %0d and >= %0d", cs_fall_cnt, min_cs_high, npk, GAPC);
      else n_pass++;
      n_total++;
      if (viol !== 0) $display("FAIL rand_protocol: got %0d violations expected 0", viol); else n_pass++;
   endtask

   initial begin
      clear_logs();
      test_reset();
      test_single_cmd();
      test_data_byte();
      test_priority();
      test_multi();
      test_stall();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
